// File: rtl/col_drain_arbiter_pkg.sv
// Shared types and width helpers for the systolic-array result drain path.
package systola_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_st_t;

  localparam int unsigned COLS_DEF     = 8;
  localparam int unsigned ROWS_DEF     = 8;
  localparam int unsigned OUTWIDTH_DEF = 32;

  // Index width for an n-entry selection; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must reach n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/col_drain_arbiter_if.sv
// Registered result stream leaving the drain arbiter, tagged with source column.
interface col_drain_arbiter_if import systola_pkg::*; #(
  parameter int unsigned COLS     = COLS_DEF,
  parameter int unsigned OUTWIDTH = OUTWIDTH_DEF
) ();

  localparam int unsigned CW = idx_w(COLS);

  logic [OUTWIDTH-1:0] out_data;
  logic [CW-1:0]       out_col;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output out_data, out_col, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_col, out_last, out_valid,
    output out_ready
  );

endinterface

// File: rtl/col_drain_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick import systola_pkg::*; #(
  parameter int unsigned COLS = COLS_DEF,
  localparam int unsigned IW  = idx_w(COLS)
) (
  input  logic [COLS-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [COLS-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int unsigned j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < COLS; i++) begin
      j = (32'(ptr) + i) % COLS;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/col_drain_arbiter.sv
// Drains ROWS results from each of COLS column controllers per tile onto one
// registered valid/ready stream, choosing columns round-robin per element.
module col_drain_arbiter import systola_pkg::*; #(
  parameter int unsigned COLS     = COLS_DEF,
  parameter int unsigned ROWS     = ROWS_DEF,
  parameter int unsigned OUTWIDTH = OUTWIDTH_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [OUTWIDTH-1:0] col_r [0:COLS-1],
  input  logic [COLS-1:0]     col_v,
  output logic [COLS-1:0]     col_read,
  col_drain_arbiter_if.master res,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CW = idx_w(COLS);
  localparam int unsigned NW = cnt_w(ROWS);
  localparam int unsigned TW = cnt_w(COLS * ROWS);
  localparam logic [NW-1:0] ROWS_N = NW'(ROWS);
  localparam logic [TW-1:0] TOTAL  = TW'(COLS * ROWS);

  drain_st_t           state_q, state_d;
  logic [CW-1:0]       ptr_q, ptr_d;
  logic [NW-1:0]       cnt_q [COLS];
  logic [NW-1:0]       cnt_d [COLS];
  logic [TW-1:0]       total_q, total_d;
  logic [OUTWIDTH-1:0] data_q, data_d;
  logic [CW-1:0]       col_q, col_d;
  logic                last_q, last_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  logic [COLS-1:0] eligible;
  logic [COLS-1:0] grant;
  logic [CW-1:0]   win;
  logic            any;
  logic            load;
  logic            hs;

  always_comb begin
    eligible = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      eligible[c] = col_v[c] && (cnt_q[c] < ROWS_N);
    end
  end

  rr_pick #(.COLS(COLS)) u_pick (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign hs   = valid_q && res.out_ready;
  assign load = (state_q == DRAIN) && any && (!valid_q || res.out_ready);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    total_d  = total_q;
    data_d   = data_q;
    col_d    = col_q;
    last_d   = last_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    col_read = '0;
    unique case (state_q)
      // done_q still high means the previous tile has only just finished.
      IDLE: begin
        if (start && !done_q) begin
          state_d = DRAIN;
          cnt_d   = '{default: '0};
          total_d = '0;
        end
      end
      DRAIN: begin
        if (load) begin
          col_read     = grant;
          data_d       = col_r[win];
          col_d        = win;
          valid_d      = 1'b1;
          cnt_d[win]   = cnt_q[win] + NW'(1);
          total_d      = total_q + TW'(1);
          ptr_d        = (win == CW'(COLS - 1)) ? '0 : win + CW'(1);
          if (total_q + TW'(1) == TOTAL) begin
            last_d  = 1'b1;
            state_d = FLUSH;
          end
        end else if (hs) begin
          valid_d = 1'b0;
        end
      end
      FLUSH: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '{default: '0};
      total_q <= '0;
      data_q  <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      data_q  <= data_d;
      col_q   <= col_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign res.out_data  = data_q;
  assign res.out_col   = col_q;
  assign res.out_last  = last_q;
  assign res.out_valid = valid_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule
